uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter inside the icebreaker top; it drives the TX pin that the board-level testbench and the host consume.
- The CPU-side register bus pushes bytes into a small FIFO through a valid/ready handshake.
- A baud-rate state machine serialises each byte LSB-first onto tx.
- The bit period is supplied at runtime so firmware can retune the baud rate without resynthesis.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, minimum 2.
DIV_MIN, 2, floor applied to the div input; effective bit period = max(div, DIV_MIN) clocks.

Ports:
clk  input  1  system clock, rising-edge
resetn  input  1  asynchronous active-low reset
wr_valid  input  1  byte-write request
wr_ready  output  1  FIFO can accept a byte; equals !full, registered
wr_data  input  8  byte to transmit
div  input  16  clocks per bit; sampled only at the start of each frame
tx  output  1  serial line; idles high
busy  output  1  high when the FIFO is non-empty or a frame is in progress
level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (async assert, sync deassert by the surrounding reset logic) forces these values:
  - tx=1, wr_ready=1, busy=0, level=0.
  - FSM in IDLE; FIFO pointers and counters cleared.
  - Asserting resetn low mid-frame drives tx high immediately (combinationally via the async clear of the tx flop) and discards all queued bytes.
- Write handshake:
  - A byte is accepted on a rising edge where wr_valid && wr_ready.
  - When full, wr_ready=0 and writes are ignored, even if a pop occurs in the same cycle; wr_ready rises on the edge after the pop.
  - wr_data need only be stable in the accepting cycle.
- FIFO:
  - Circular buffer with ($clog2(DEPTH)+1)-bit pointers; wrap is handled by the extra MSB.
  - full = pointers differ only in MSB; empty = pointers equal.
  - A simultaneous push and pop (when not full) leaves level unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - A bit counter baud_cnt counts down from eff_div-1 to 0; each state bit lasts exactly eff_div clocks.
  - eff_div = max(div, DIV_MIN), latched at the pop edge.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, latch eff_div, set tx=0 and go to START.
  - START: when baud_cnt==0, drive tx=shift[0] and go to DATA with bit index 0.
  - DATA: when baud_cnt==0, do one of the following:
    - If bit index < 7: shift right, drive the next bit, increment the index.
    - Otherwise: drive tx=1 and go to STOP.
  - STOP: when baud_cnt==0, do one of the following:
    - If the FIFO is non-empty: pop, latch div, tx=0 and go to START. There is no idle gap between back-to-back frames.
    - Otherwise: go to IDLE.
  - A frame lasts exactly 10*eff_div clocks.
- Latency: a byte accepted at edge N into an empty FIFO with FSM in IDLE pops at edge N+1; tx is low from edge N+1.
- tx is driven from a flop only; there are no combinational glitches on the pin.
- Changing div mid-frame has no effect until the next pop.
- level is updated on the same edge as the push/pop; busy = !empty || state!=IDLE.

Test Plan:
1. div=4, write 0x55 -> tx sequence of 4-clock bits: 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop); total 40 clocks; busy falls one cycle after the stop bit ends.
2. div=1 (below floor), write 0xA3 -> each bit lasts 2 clocks; bits observed 0,1,1,0,0,0,1,0,1,1; frame 20 clocks.
3. div=3, write 0x00,0xFF back-to-back -> the second start bit immediately follows the first stop bit with zero idle cycles; total 60 clocks of activity.
4. DEPTH=16, hold wr_valid for 20 cycles while the first frame is in progress -> exactly 17 bytes accepted (16 stored plus 1 popped at the first edge); wr_ready=0 thereafter until the next pop; level peaks at 16.
5. Reset mid-DATA of 0x0F with 3 bytes queued -> tx=1 within the same cycle as resetn low; level=0, busy=0; no further frames after release.
6. div changed from 4 to 8 during frame 1 of two queued bytes -> frame 1 keeps 4-clock bits; frame 2 uses 8-clock bits.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Buffered 8N1 UART transmitter: byte FIFO plus runtime-divided
//             baud-rate serialiser driving an idle-high TX pin.
//  Revision : 1.0 - initial release
// ============================================================================

module uart_tx_fifo #(
   parameter int DEPTH   = 16,
   parameter int DIV_MIN = 2
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [7:0]               wr_data,
   input  logic [15:0]              div,
   output logic                     tx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int          c_aw      = $clog2(DEPTH);
   localparam int          c_pw      = c_aw + 1;
   localparam logic [15:0] c_div_min = 16'(DIV_MIN);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic [7:0]      r_mem [DEPTH];
   logic [c_pw-1:0] r_wptr;
   logic [c_pw-1:0] r_rptr;
   logic [c_pw-1:0] r_level;
   logic            r_wr_ready;

   state_t          r_state;
   logic [15:0]     r_baud_cnt;
   logic [15:0]     r_div;
   logic [7:0]      r_shift;
   logic [2:0]      r_bit_idx;
   logic            r_tx;

   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_baud_done;
   logic [15:0]     w_eff_div;
   logic [7:0]      w_head;
   logic [c_pw-1:0] w_wptr_nxt;
   logic [c_pw-1:0] w_rptr_nxt;
   logic            w_full_nxt;

   assign w_empty     = (r_wptr == r_rptr);
   // r_wr_ready always mirrors !full, so a full FIFO ignores writes even on a pop edge
   assign w_push      = wr_valid && r_wr_ready;
   assign w_baud_done = (r_baud_cnt == 16'd0);
   assign w_pop       = !w_empty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));
   assign w_eff_div   = (div < c_div_min) ? c_div_min : div;
   assign w_head      = r_mem[r_rptr[c_aw-1:0]];

   assign w_wptr_nxt  = w_push ? (r_wptr + c_pw'(1)) : r_wptr;
   assign w_rptr_nxt  = w_pop  ? (r_rptr + c_pw'(1)) : r_rptr;
   assign w_full_nxt  = (w_wptr_nxt[c_aw] != w_rptr_nxt[c_aw]) &&
                        (w_wptr_nxt[c_aw-1:0] == w_rptr_nxt[c_aw-1:0]);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[c_aw-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_wr_ready <= 1'b1;
      end else begin
         r_wptr     <= w_wptr_nxt;
         r_rptr     <= w_rptr_nxt;
         r_wr_ready <= !w_full_nxt;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_pw'(1);
            2'b01:   r_level <= r_level - c_pw'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Each state holds its bit for r_div clocks; r_div is frozen at the pop edge
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_div      <= c_div_min;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_tx       <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift    <= w_head;
                  r_div      <= w_eff_div;
                  r_baud_cnt <= w_eff_div - 16'd1;
                  r_tx       <= 1'b0;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               if (w_baud_done) begin
                  r_tx       <= r_shift[0];
                  r_bit_idx  <= 3'd0;
                  r_baud_cnt <= r_div - 16'd1;
                  r_state    <= S_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (w_baud_done) begin
                  r_baud_cnt <= r_div - 16'd1;
                  if (r_bit_idx != 3'd7) begin
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt - 16'd1;
               end
            end
            S_STOP: begin
               if (w_baud_done) begin
                  if (w_pop) begin
                     // back-to-back frame: start bit follows the stop bit directly
                     r_shift    <= w_head;
                     r_div      <= w_eff_div;
                     r_baud_cnt <= w_eff_div - 16'd1;
                     r_tx       <= 1'b0;
                     r_state    <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt - 16'd1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign wr_ready = r_wr_ready;
   assign tx       = r_tx;
   assign level    = r_level;
   assign busy     = !w_empty || (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Scoreboard bench for uart_tx_fifo with a frame-level reference
//             model and a decoupled TX-line monitor.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_uart_tx_fifo;

   localparam int DEPTH   = 16;
   localparam int DIV_MIN = 2;

   typedef struct {
      int data;
      int eff;
      int start;
   } frame_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_data;
   logic [15:0] div;
   logic        tx;
   logic        busy;
   logic [$clog2(DEPTH):0] level;

   int checks = 0;
   int errors = 0;

   // reference model state (post-edge view)
   logic [7:0] mq[$];
   frame_t     exp_q[$];
   int         cyc = 0;
   bit         m_active = 0;
   int         m_el = 0;
   int         m_eff = DIV_MIN;

   // monitor state
   bit     mon_active = 0;
   frame_t mon_f;
   int     mon_e = 0;
   int     mon_bad = 0;
   int     busy_cnt = 0;
   int     txlow_cnt = 0;

   uart_tx_fifo #(.DEPTH(DEPTH), .DIV_MIN(DIV_MIN)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .div      (div),
      .tx       (tx),
      .busy     (busy),
      .level    (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame-level model: a frame occupies 10*eff clocks from its pop edge; the
   // next frame may pop on the edge that ends the previous one.
   initial begin
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            mq.delete();
            exp_q.delete();
            m_active = 0;
            m_el     = 0;
         end else begin
            int  sz0;
            bit  acc;
            cyc++;
            sz0 = mq.size();
            acc = wr_valid && (sz0 < DEPTH);
            if (m_active) begin
               m_el++;
               if (m_el == 10 * m_eff) m_active = 0;
            end
            if (!m_active && sz0 > 0) begin
               frame_t f;
               f.data   = int'(mq.pop_front());
               f.eff    = (int'(div) < DIV_MIN) ? DIV_MIN : int'(div);
               f.start  = cyc;
               m_eff    = f.eff;
               m_active = 1;
               m_el     = 0;
               exp_q.push_back(f);
            end
            if (acc) mq.push_back(wr_data);
         end
      end
   end

   // Monitor: status outputs every cycle, TX frames against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            mon_active = 0;
         end else begin
            chk("wr_ready", int'(wr_ready), int'(mq.size() < DEPTH));
            chk("level", int'(level), mq.size());
            chk("busy", int'(busy), int'((mq.size() > 0) || m_active));
            busy_cnt  += int'(busy);
            txlow_cnt += int'(!tx);
            if (!mon_active && tx == 1'b0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_start", 1, 0);
               end else begin
                  mon_f      = exp_q.pop_front();
                  mon_active = 1;
                  mon_e      = 0;
                  mon_bad    = 0;
                  chk("frame_start_cycle", cyc, mon_f.start);
               end
            end
            if (mon_active) begin
               int idx;
               int expb;
               idx = mon_e / mon_f.eff;
               if (idx == 0)      expb = 0;
               else if (idx == 9) expb = 1;
               else               expb = (mon_f.data >> (idx - 1)) & 1;
               if (int'(tx) != expb) mon_bad++;
               mon_e++;
               if (mon_e == 10 * mon_f.eff) begin
                  chk("frame_bit_errors", mon_bad, 0);
                  mon_active = 0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      int t = 0;
      wr_valid = 1'b1;
      wr_data  = d;
      while (!wr_ready && t < 5000) begin
         tick();
         t++;
      end
      chk("push_timeout", int'(t >= 5000), 0);
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      do begin
         tick();
         t++;
      end while ((busy || mon_active || exp_q.size() != 0) && t < 20000);
      chk("idle_timeout", int'(t >= 20000), 0);
   endtask

   task automatic run_frames(input string name, input int txlow_exp, input int busy_exp);
      chk({name, "_txlow"}, txlow_cnt, txlow_exp);
      chk({name, "_busy"}, busy_cnt, busy_exp);
   endtask

   initial begin
      int acc;
      int peak;
      resetn   = 1'b0;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      div      = 16'd4;
      repeat (3) tick();
      chk("rst_tx", int'(tx), 1);
      chk("rst_wr_ready", int'(wr_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_level", int'(level), 0);
      resetn = 1'b1;
      repeat (2) tick();

      // 1: div=4, 0x55
      busy_cnt = 0; txlow_cnt = 0;
      push(8'h55);
      wait_idle();
      run_frames("t1", 20, 41);

      // 2: div below floor, 0xA3
      div = 16'd1;
      busy_cnt = 0; txlow_cnt = 0;
      push(8'hA3);
      wait_idle();
      run_frames("t2", 10, 21);

      // 3: back-to-back 0x00, 0xFF at div=3
      div = 16'd3;
      busy_cnt = 0; txlow_cnt = 0;
      push(8'h00);
      push(8'hFF);
      wait_idle();
      run_frames("t3", 30, 61);

      // 4: hold wr_valid for 20 cycles at div=4
      div      = 16'd4;
      acc      = 0;
      peak     = 0;
      wr_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         acc += int'(wr_ready);
         wr_data = 8'($urandom);
         tick();
         if (int'(level) > peak) peak = int'(level);
      end
      wr_valid = 1'b0;
      chk("t4_accepted", acc, 17);
      chk("t4_peak_level", peak, DEPTH);
      chk("t4_ready_low", int'(wr_ready), 0);
      wait_idle();

      // 6: div 4 -> 8 during frame 1
      busy_cnt = 0; txlow_cnt = 0;
      push(8'h0F);
      push(8'hF0);
      repeat (10) tick();
      div = 16'd8;
      wait_idle();
      run_frames("t6", 60, 121);

      // 5: reset mid-DATA with 3 bytes queued
      div = 16'd4;
      push(8'h0F);
      push(8'h11);
      push(8'h22);
      push(8'h33);
      repeat (12) tick();
      resetn = 1'b0;
      #1;
      chk("t5_tx", int'(tx), 1);
      chk("t5_level", int'(level), 0);
      chk("t5_busy", int'(busy), 0);
      chk("t5_wr_ready", int'(wr_ready), 1);
      repeat (3) tick();
      resetn = 1'b1;
      repeat (60) tick();
      chk("t5_post_busy", int'(busy), 0);
      chk("t5_post_level", int'(level), 0);

      // randomized traffic with occasional baud changes
      for (int i = 0; i < 800; i++) begin
         wr_valid = ($urandom_range(0, 2) == 0);
         wr_data  = 8'($urandom);
         if ($urandom_range(0, 49) == 0) div = 16'($urandom_range(0, 6));
         tick();
      end
      wr_valid = 1'b0;
      wait_idle();
      chk("sb_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
